// File: rtl/serial_cmp_pkg.sv
// Shared types and reset constants for the bit-serial magnitude comparator.
// Exports: state_t (IDLE/RUN/DONE), E_INIT and G_INIT chain seeds.
package serial_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic E_INIT = 1'b1;
   localparam logic G_INIT = 1'b0;

endpackage

// File: rtl/cmp_bit_slice.sv
// One-bit compare slice: folds a bit pair into the (e, g) chain.
// Ports: a, b bits; e_in/g_in chain in; e_out/g_out chain out.
module cmp_bit_slice (
   input  logic a,
   input  logic b,
   input  logic e_in,
   input  logic g_in,
   output logic e_out,
   output logic g_out
);

   assign e_out = ~(a ^ b) & e_in;
   assign g_out = g_in | (~a & b & e_in);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator with valid/ready handshakes.
// Ports: clk, rst_n (async low); in_valid/in_ready, a_in, b_in operands;
// out_valid/out_ready result; eq, b_gt_a, a_gt_b flags; busy in RUN.
// Option: SERIAL_CMP_EARLY_EXIT_EN stops RUN at the first differing bit.
module serial_magnitude_comparator
   import serial_cmp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             b_gt_a,
   output logic             a_gt_b,
   output logic             busy
);

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [CNT_W-1:0] cnt;
   logic             e_q;
   logic             g_q;

   logic a_bit;
   logic b_bit;
   logic e_nx;
   logic g_nx;
   logic last;

   assign a_bit = a_q[cnt];
   assign b_bit = b_q[cnt];

   cmp_bit_slice u_slice (
      .a     (a_bit),
      .b     (b_bit),
      .e_in  (e_q),
      .g_in  (g_q),
      .e_out (e_nx),
      .g_out (g_nx)
   );

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   // A mismatch fixes the result; lower bits cannot change it.
   assign last = (cnt == '0) | ~e_nx;
`else
   assign last = (cnt == '0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= CNT_W'(WIDTH - 1);
         e_q       <= E_INIT;
         g_q       <= G_INIT;
         a_q       <= '0;
         b_q       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         eq        <= 1'b0;
         b_gt_a    <= 1'b0;
         a_gt_b    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a_in;
                  b_q      <= b_in;
                  e_q      <= E_INIT;
                  g_q      <= G_INIT;
                  cnt      <= CNT_W'(WIDTH - 1);
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               e_q <= e_nx;
               g_q <= g_nx;
               if (last) begin
                  // Flags come straight from the slice so they
                  // appear together with out_valid.
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  eq        <= e_nx;
                  b_gt_a    <= g_nx;
                  a_gt_b    <= ~e_nx & ~g_nx;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator.
// Table vectors, DONE-stall, mid-RUN reset and random pairs via scoreboard.
module tb_serial_magnitude_comparator;

   localparam int W = 8;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         eq;
   logic         b_gt_a;
   logic         a_gt_b;
   logic         busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   flags;
   } vec_t;

   typedef struct {
      logic [2:0] flags;
      int         lat;
   } exp_t;

   exp_t sbq[$];
   vec_t tbl[6];

   always #5 clk = ~clk;

   serial_magnitude_comparator #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .eq        (eq),
      .b_gt_a    (b_gt_a),
      .a_gt_b    (a_gt_b),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] ref_flags(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      if (a == b)     return 3'b100;
      else if (b > a) return 3'b010;
      else            return 3'b001;
   endfunction

   function automatic int exp_lat(input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      int hi = -1;
      for (int i = 0; i < W; i++)
         if (a[i] != b[i]) hi = i;
      return (EARLY && hi >= 0) ? W - hi : W;
   endfunction

   task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int stall, input bit poke);
      exp_t       x;
      exp_t       y;
      int         n;
      bit         seen;
      logic [2:0] held;
      x.flags = ref_flags(a, b);
      x.lat   = exp_lat(a, b);
      sbq.push_back(x);
      @(negedge clk);
      chk("idle_ready", in_ready, 1);
      a_in      = a;
      b_in      = b;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("run_busy", {busy, in_ready}, 2'b10);
      n    = 0;
      seen = 0;
      while (!seen && n < 4 * W) begin
         @(posedge clk);
         #1;
         n++;
         seen = out_valid;
      end
      chk("result_timeout", seen, 1);
      y = sbq.pop_front();
      if (seen) begin
         chk("latency", n, y.lat);
         chk("flags", {eq, b_gt_a, a_gt_b}, y.flags);
         chk("one_hot", $countones({eq, b_gt_a, a_gt_b}), 1);
         held = {eq, b_gt_a, a_gt_b};
         for (int i = 0; i < stall; i++) begin
            if (poke) begin
               a_in     = ~a;
               b_in     = a;
               in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            chk("done_hold",
                {out_valid, in_ready, busy, eq, b_gt_a, a_gt_b},
                {3'b100, held});
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         chk("done_exit", {out_valid, in_ready, busy}, 3'b010);
         out_ready = 1'b0;
      end
   endtask

   initial begin
      int ov;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      tbl[0] = '{8'h5A, 8'h5A, 3'b100};
      tbl[1] = '{8'h80, 8'h7F, 3'b001};
      tbl[2] = '{8'h00, 8'hFF, 3'b010};
      tbl[3] = '{8'h12, 8'h13, 3'b010};
      tbl[4] = '{8'hFF, 8'hFE, 3'b001};
      tbl[5] = '{8'h00, 8'h00, 3'b100};

      #12;
      chk("reset_outs",
          {in_ready, out_valid, eq, b_gt_a, a_gt_b, busy}, 6'b100000);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         chk("tbl_model", ref_flags(tbl[i].a, tbl[i].b), tbl[i].flags);
         run_pair(tbl[i].a, tbl[i].b, 0, 0);
      end
      chk("lat_lsb", exp_lat(8'h12, 8'h13), W);
      chk("lat_msb", exp_lat(8'h80, 8'h7F), EARLY ? 1 : W);

      run_pair(8'h34, 8'h91, 5, 1);
      run_pair(8'hC7, 8'hC7, 0, 0);

      @(negedge clk);
      a_in      = 8'h3C;
      b_in      = 8'h3C;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset",
          {in_ready, out_valid, eq, b_gt_a, a_gt_b, busy}, 6'b100000);
      @(negedge clk);
      rst_n = 1'b1;
      ov = 0;
      repeat (W + 4) begin
         @(posedge clk);
         #1;
         if (out_valid) ov++;
      end
      chk("no_result_after_reset", ov, 0);
      out_ready = 1'b0;
      run_pair(8'h3C, 8'hC3, 2, 0);

      for (int i = 0; i < 200; i++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
         run_pair(ra, rb, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
